// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
//   state_e : sequencer FSM states
//   cnt_w   : width of the bit counter for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell.
//   x, y : input bits
//   s    : sum bit   (x ^ y)
//   c    : carry bit (x & y)
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: one full-adder bit (two half-adder cells) reused over WIDTH cycles,
// LSB first, to compute {cout, sum} = a + b + cin.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (a, b, cin)
//   out_valid/out_ready: result handshake (sum, cout)
//   busy               : sequencer not idle
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic p, g0, s_bit, g1, carry_next;

  // Full-adder bit on the current LSBs of the operand shift registers.
  ha_cell u_ha0 (
    .x (ra_q[0]),
    .y (rb_q[0]),
    .s (p),
    .c (g0)
  );

  ha_cell u_ha1 (
    .x (p),
    .y (carry_q),
    .s (s_bit),
    .c (g1)
  );

  assign carry_next = g0 | g1;

  // rst gates in_ready so an operand presented while reset is released is not taken.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at sum[0].
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        carry_d = carry_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d      = carry_next;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8).
module tb_serial_add_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Counts rising edges until out_valid is seen 1 ns after an edge; -1 if the budget runs out.
  task automatic wait_out(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
      if (n >= 40) begin
        n = -1;
        break;
      end
    end
  endtask

  // Presents operands at a falling edge and lets the next rising edge accept them.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0
        || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b sum=%h cout=%b busy=%b in_ready=%b want 0/00/0/0/0",
               out_valid, sum, cout, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    send(8'h05, 8'h03, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    wait_out(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges want 8", n);
    end
    checks++;
    if (sum !== 8'h08 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %b_%h want 0_08", cout, sum);
    end
    drain();
  endtask

  task automatic test_carry();
    int n;
    send(8'hFF, 8'h01, 1'b0);
    wait_out(n);
    checks++;
    if (n != 8 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_01: got n=%0d %b_%h want n=8 1_00", n, cout, sum);
    end
    drain();
    send(8'hFF, 8'hFF, 1'b1);
    wait_out(n);
    checks++;
    if (n != 8 || sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_ff_1: got n=%0d %b_%h want n=8 1_ff", n, cout, sum);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    send(8'h0A, 8'h0B, 1'b1);
    wait_out(n);
    // Offer another operand while the result is held; it must be ignored.
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h16 || cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: ov=%b %b_%h in_ready=%b want 1 0_16 0",
                 i, out_valid, cout, sum, in_ready);
      end
    end
    in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h16) begin
      errors++;
      $display("FAIL backpressure_after: busy=%b ov=%b sum=%h want 0/0/16", busy, out_valid, sum);
    end
  endtask

  task automatic test_churn();
    int n;
    int results;
    send(8'h12, 8'h34, 1'b0);
    in_valid = 1'b1;
    n = 0;
    results = 0;
    while (!out_valid && n < 40) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 8 || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL churn_result: got n=%0d %b_%h want n=8 0_46", n, cout, sum);
    end
    drain();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) results++;
    end
    checks++;
    if (results != 0) begin
      errors++;
      $display("FAIL churn_single_result: extra activity cycles=%0d want 0", results);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    send(8'h77, 8'h11, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: ov=%b sum=%h cout=%b busy=%b want 0/00/0/0",
               out_valid, sum, cout, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h10, 8'h20, 1'b0);
    wait_out(n);
    checks++;
    if (n != 8 || sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got n=%0d %b_%h want n=8 0_30", n, cout, sum);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] va [3] = '{8'h5A, 8'hC8, 8'h80};
    logic [WIDTH-1:0] vb [3] = '{8'h33, 8'h64, 8'h80};
    logic             vc [3] = '{1'b1, 1'b0, 1'b1};
    logic [WIDTH:0]   exp_r [3] = '{9'h08E, 9'h12C, 9'h101};
    int seen;
    int cyc;
    int last_cyc;
    @(negedge clk);
    a = va[0];
    b = vb[0];
    cin = vc[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    cyc = 0;
    last_cyc = 0;
    while (seen < 3 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        checks++;
        if ({cout, sum} !== exp_r[seen]) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h want %h", seen, {cout, sum}, exp_r[seen]);
        end
        if (seen > 0) begin
          checks++;
          if (cyc - last_cyc != WIDTH + 2) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", seen, cyc - last_cyc, WIDTH + 2);
          end
        end
        last_cyc = cyc;
        seen++;
        if (seen < 3) begin
          a = va[seen];
          b = vb[seen];
          cin = vc[seen];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 3", seen);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_churn();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Bit-serial add sequencer. It reuses one 1-bit full-adder cell, built from two half-adder cells, over WIDTH cycles to add two WIDTH-bit operands plus carry-in, LSB first. It sits between a tile's input pins and output pins. Both sides use a valid/ready handshake, so the area cost is one adder bit plus shift registers instead of a WIDTH-bit adder.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands; combinational, equals (state==IDLE) && !rst
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result valid; registered
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result bits [WIDTH-1:0]; registered
cout  output  1  final carry-out; registered
busy  output  1  state != IDLE; combinational

Behaviour:
- Interface is fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asserted at any time, including mid-operation): state=IDLE, bit counter=0, operand shift regs=0, carry reg=0, sum=0, cout=0, out_valid=0. Any partial result is discarded and no output handshake occurs.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a->ra, b->rb, cin->carry; clear cnt; go to RUN.
- RUN, one bit per cycle:
  - ha0: p=ra[0]^rb[0], g0=ra[0]&rb[0].
  - ha1: s=p^carry, g1=p&carry.
  - Next carry is g0|g1.
  - sum shifts right with s inserted at MSB. ra and rb shift right, filling with 0.
  - cnt increments; it is $clog2(WIDTH) bits wide.
  - When cnt==WIDTH-1: go to DONE, load cout with the final carry, set out_valid=1.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. sum and cout keep their value until the next result.
- Latency: handshake accepted at edge E0; out_valid is high after edge E0+WIDTH. Throughput is one result per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, drain).
- Handshake rules:
  - in_ready=0 in RUN and DONE, so in_valid is ignored there.
  - Changes on a/b/cin after acceptance have no effect.
  - out_valid must not drop until out_ready is seen.
  - There is no IDLE/DONE overlap: a new accept cannot happen on the same edge as the output drain.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- rst deasserting on the same edge as in_valid=1: the operand is not accepted, because in_ready was 0 while rst was high.

Decomposition:
- Package serial_add_pkg:
  - State enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function cnt_w(WIDTH) = $clog2(WIDTH).
- Sub-module ha_cell (ports x, y -> s=x^y, c=x&y), instantiated twice inside serial_add_seq to form the full-adder bit.
- No other hierarchy.

Test Plan:
All scenarios use WIDTH=8.
1. a=0x05, b=0x03, cin=0, in_valid for 1 cycle -> in_ready drops next cycle; out_valid rises exactly 8 edges after accept; sum=0x08, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, sum and cout are stable; in_ready=0; a new in_valid is ignored. Then out_ready=1 -> next cycle out_valid=0 and in_ready=1.
4. Operand churn: accept a=0x12, b=0x34, then randomize a/b/cin and hold in_valid=1 during RUN -> sum=0x46, cout=0; exactly one result is produced.
5. Reset mid-RUN: assert rst asynchronously at the 4th RUN cycle -> out_valid=0, sum=0, cout=0, busy=0 immediately. After release, a=0x10, b=0x20 -> sum=0x30.
6. Back-to-back: in_valid=1 and out_ready=1 held constantly with 3 operand sets -> 3 results, each WIDTH+2 cycles apart, all matching a+b+cin.
